// File: rtl/frame_energy_acc.sv
// frame_energy_acc
// Accumulates the energy (sum of squared signed samples) of consecutive
// frames of FRAME_LEN samples and writes one energy word per frame into an
// external buffer at address = frame index. After NUM_FRAMES frames a
// one-cycle copy_energy_en pulse hands the buffer to the downstream copy
// controller.
//
// State | meaning
// IDLE  | waiting for start
// ACCUM | accepting samples, accumulating squared samples
// WRITE | one-cycle write of the finished frame energy
// NEXT  | advance to next frame, or finish the run
// DONE  | one-cycle copy_energy_en pulse
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   start             run request (honoured in IDLE only)
//   sample_valid/data signed sample stream, taken when sample_ready is high
//   sample_ready      high while accumulating
//   energy_wr_*       energy buffer write port (addr/data zero when idle)
//   busy              high outside IDLE
//   copy_energy_en    end-of-run pulse
module frame_energy_acc #(
    parameter int DATA_WIDTH = 16,
    parameter int ACC_WIDTH  = 40,
    parameter int ADDR_WIDTH = 12,
    parameter int FRAME_LEN  = 256,
    parameter int NUM_FRAMES = 49
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic                         sample_valid,
    input  logic signed [DATA_WIDTH-1:0] sample_data,
    output logic                         sample_ready,
    output logic                         energy_wr_en,
    output logic [ADDR_WIDTH-1:0]        energy_wr_addr,
    output logic [ACC_WIDTH-1:0]         energy_wr_data,
    output logic                         busy,
    output logic                         copy_energy_en
);

    localparam int SQ_W  = 2 * DATA_WIDTH;
    // One extra bit so the carry out of the add is visible for saturation.
    localparam int SUM_W = ((ACC_WIDTH > SQ_W) ? ACC_WIDTH : SQ_W) + 1;
    localparam int CNT_W = 12;
    localparam logic [CNT_W-1:0]      LAST_SAMPLE = CNT_W'(FRAME_LEN - 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_FRAME  = ADDR_WIDTH'(NUM_FRAMES - 1);
    localparam logic [ACC_WIDTH-1:0]  ACC_MAX     = {ACC_WIDTH{1'b1}};

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ACCUM = 3'd1,
        WRITE = 3'd2,
        NEXT  = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0]   frame_q, frame_d;
    logic [ACC_WIDTH-1:0]    acc_q, acc_d;
    logic                    sample_ready_q, sample_ready_d;
    logic                    wr_en_q, wr_en_d;
    logic [ADDR_WIDTH-1:0]   wr_addr_q, wr_addr_d;
    logic [ACC_WIDTH-1:0]    wr_data_q, wr_data_d;
    logic                    busy_q, busy_d;
    logic                    copy_q, copy_d;

    logic signed [SQ_W-1:0]  sample_ext;
    logic signed [SQ_W-1:0]  sq_s;
    logic [SQ_W-1:0]         sq;
    logic [SUM_W-1:0]        sum;
    logic [ACC_WIDTH-1:0]    acc_sat;

    // Saturating square-accumulate. The square of a signed value is never
    // negative and always fits in 2*DATA_WIDTH bits as an unsigned number.
    always_comb begin
        sample_ext = SQ_W'(sample_data);
        sq_s       = sample_ext * sample_ext;
        sq         = $unsigned(sq_s);
        sum        = SUM_W'(acc_q) + SUM_W'(sq);
        acc_sat    = (sum > SUM_W'(ACC_MAX)) ? ACC_MAX : sum[ACC_WIDTH-1:0];
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        frame_d = frame_q;
        acc_d   = acc_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = ACCUM;
                    cnt_d   = '0;
                    frame_d = '0;
                    acc_d   = '0;
                end
            end
            ACCUM: begin
                if (sample_valid) begin
                    acc_d = acc_sat;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST_SAMPLE) begin
                        state_d = WRITE;
                    end
                end
            end
            WRITE: state_d = NEXT;
            NEXT: begin
                if (frame_q == LAST_FRAME) begin
                    state_d = DONE;
                end else begin
                    state_d = ACCUM;
                    frame_d = frame_q + 1'b1;
                    cnt_d   = '0;
                    acc_d   = '0;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Outputs are decoded from the next state so they are registered yet
        // line up with the state they describe.
        sample_ready_d = (state_d == ACCUM);
        wr_en_d        = (state_d == WRITE);
        wr_addr_d      = wr_en_d ? frame_d : '0;
        wr_data_d      = wr_en_d ? acc_d : '0;
        busy_d         = (state_d != IDLE);
        copy_d         = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            frame_q        <= '0;
            acc_q          <= '0;
            sample_ready_q <= 1'b0;
            wr_en_q        <= 1'b0;
            wr_addr_q      <= '0;
            wr_data_q      <= '0;
            busy_q         <= 1'b0;
            copy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            frame_q        <= frame_d;
            acc_q          <= acc_d;
            sample_ready_q <= sample_ready_d;
            wr_en_q        <= wr_en_d;
            wr_addr_q      <= wr_addr_d;
            wr_data_q      <= wr_data_d;
            busy_q         <= busy_d;
            copy_q         <= copy_d;
        end
    end

    assign sample_ready   = sample_ready_q;
    assign energy_wr_en   = wr_en_q;
    assign energy_wr_addr = wr_addr_q;
    assign energy_wr_data = wr_data_q;
    assign busy           = busy_q;
    assign copy_energy_en = copy_q;

endmodule

// File: tb/tb_frame_energy_acc.sv
// Testbench for frame_energy_acc.
// dut_a: FRAME_LEN=4, NUM_FRAMES=2, ACC_WIDTH=40 (table, random, reset, restart)
// dut_b: FRAME_LEN=8, NUM_FRAMES=1, ACC_WIDTH=33 (saturation)
module tb_frame_energy_acc;

    localparam int FL_A = 4;
    localparam int NF_A = 2;
    localparam longint MAX40 = (longint'(1) << 40) - 1;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // dut_a signals
    logic        start_a = 1'b0, valid_a = 1'b0;
    logic [15:0] data_a = '0;
    logic        ready_a, wr_en_a, busy_a, copy_a;
    logic [11:0] wr_addr_a;
    logic [39:0] wr_data_a;

    // dut_b signals
    logic        start_b = 1'b0, valid_b = 1'b0;
    logic [15:0] data_b = '0;
    logic        ready_b, wr_en_b, busy_b, copy_b;
    logic [11:0] wr_addr_b;
    logic [32:0] wr_data_b;

    frame_energy_acc #(.DATA_WIDTH(16), .ACC_WIDTH(40), .ADDR_WIDTH(12),
                       .FRAME_LEN(FL_A), .NUM_FRAMES(NF_A)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .sample_valid(valid_a),
        .sample_data(data_a), .sample_ready(ready_a), .energy_wr_en(wr_en_a),
        .energy_wr_addr(wr_addr_a), .energy_wr_data(wr_data_a), .busy(busy_a),
        .copy_energy_en(copy_a));

    frame_energy_acc #(.DATA_WIDTH(16), .ACC_WIDTH(33), .ADDR_WIDTH(12),
                       .FRAME_LEN(8), .NUM_FRAMES(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .sample_valid(valid_b),
        .sample_data(data_b), .sample_ready(ready_b), .energy_wr_en(wr_en_b),
        .energy_wr_addr(wr_addr_b), .energy_wr_data(wr_data_b), .busy(busy_b),
        .copy_energy_en(copy_b));

    int checks = 0;
    int errors = 0;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endfunction

    // ---------------- scoreboard / monitor for dut_a ----------------
    int          drv_q[$];
    int          exp_addr_q[$];
    logic [39:0] exp_data_q[$];
    int          exp_copies_a = 0;
    int          copies_a = 0;
    int          acc_cnt_a = 0;
    int          cyc = 0;
    int          last_acc_cyc = 0;
    int          last_wr_cyc = 0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (!rst_n) begin
            acc_cnt_a = 0;
        end else begin
            if (valid_a && ready_a) begin
                acc_cnt_a++;
                if (acc_cnt_a % FL_A == 0) last_acc_cyc = cyc;
            end
            if (wr_en_a || copy_a)
                check("a_wr_copy_exclusive", {62'd0, wr_en_a, copy_a} == 64'd3, 64'd0);
            if (!wr_en_a)
                check("a_idle_addr_data_zero", {12'd0, wr_addr_a, wr_data_a}, 64'd0);
            if (wr_en_a) begin
                check("a_write_latency", cyc, last_acc_cyc + 1);
                last_wr_cyc = cyc;
                if (exp_addr_q.size() == 0) begin
                    check("a_unexpected_write", 64'd1, 64'd0);
                end else begin
                    check("a_wr_addr", wr_addr_a, exp_addr_q.pop_front());
                    check("a_wr_data", wr_data_a, exp_data_q.pop_front());
                end
            end
            if (copy_a) begin
                copies_a++;
                check("a_copy_latency", cyc, last_wr_cyc + 2);
                if (copies_a > exp_copies_a) check("a_unexpected_copy", copies_a, exp_copies_a);
            end
        end
    end

    // ---------------- monitor for dut_b ----------------
    int wr_b_cnt = 0;
    int cp_b_cnt = 0;
    always @(negedge clk) begin
        if (rst_n) begin
            if (wr_en_b) begin
                wr_b_cnt++;
                check("b_wr_addr", wr_addr_b, 64'd0);
                check("b_wr_data_saturated", wr_data_b, 64'd8589934591);
            end
            if (copy_b) cp_b_cnt++;
        end
    end

    // ---------------- drivers ----------------
    // mode 0: valid every ready cycle; 1: random gaps; 2: 1,0,0 pattern
    task automatic feed_a(input int n, input int mode);
        int idx = 0;
        int pk = 0;
        bit want;
        for (int g = 0; g < 400 && idx < n; g++) begin
            @(posedge clk); #1;
            valid_a = 1'b0;
            if (ready_a) begin
                case (mode)
                    0:       want = 1'b1;
                    1:       want = ($urandom_range(0, 3) != 0);
                    default: want = (pk % 3 == 0);
                endcase
                pk++;
                if (want) begin
                    valid_a = 1'b1;
                    data_a  = 16'(drv_q[idx]);
                    idx++;
                end
            end
        end
        @(posedge clk); #1 valid_a = 1'b0;
        check("a_feed_complete", idx, n);
    endtask

    task automatic wait_done_a();
        int k = 0;
        while (copies_a < exp_copies_a && k < 300) begin
            @(negedge clk); #1;
            k++;
        end
        check("a_copy_seen", copies_a, exp_copies_a);
        check("a_writes_drained", exp_addr_q.size(), 0);
    endtask

    // start_kind 0: pulse, 1: raise and hold, 2: already running (drop start)
    task automatic run_a(input int mode, input int start_kind, input bit use_tab,
                         input logic [39:0] te0, input logic [39:0] te1);
        longint e;
        longint x;
        for (int f = 0; f < NF_A; f++) begin
            if (use_tab) begin
                e = (f == 0) ? longint'(te0) : longint'(te1);
            end else begin
                e = 0;
                for (int j = 0; j < FL_A; j++) begin
                    x = drv_q[f*FL_A + j];
                    e += x * x;
                end
                if (e > MAX40) e = MAX40;
            end
            exp_addr_q.push_back(f);
            exp_data_q.push_back(40'(e));
        end
        exp_copies_a++;
        if (start_kind == 0) begin
            @(posedge clk); #1 start_a = 1'b1;
            @(posedge clk); #1 start_a = 1'b0;
        end else if (start_kind == 1) begin
            @(posedge clk); #1 start_a = 1'b1;
        end else begin
            start_a = 1'b0;
        end
        feed_a(FL_A * NF_A, mode);
        wait_done_a();
    endtask

    typedef struct packed {
        logic [7:0][15:0] s;   // s[0] is the first sample
        logic [39:0]      e0;
        logic [39:0]      e1;
    } vec_t;

    vec_t tv [4];

    initial begin
        tv[0].s  = {16'd5, 16'd0, 16'd0, 16'd0, 16'hFFFC, 16'd3, 16'hFFFE, 16'd1};
        tv[0].e0 = 40'd30;
        tv[0].e1 = 40'd25;
        tv[1].s  = {8{16'h8000}};
        tv[1].e0 = 40'd4294967296;
        tv[1].e1 = 40'd4294967296;
        tv[2].s  = {16'd1, 16'hFFFF, 16'd1, 16'hFFFF, 16'd0, 16'd7, 16'hFF9C, 16'd100};
        tv[2].e0 = 40'd20049;
        tv[2].e1 = 40'd4;
        tv[3].s  = {16'd0, 16'd0, 16'd0, 16'd0, {4{16'h7FFF}}};
        tv[3].e0 = 40'd4294705156;
        tv[3].e1 = 40'd0;

        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #3;
        check("reset_outputs_a", {busy_a, ready_a, wr_en_a, copy_a, wr_addr_a, wr_data_a}, 64'd0);
        check("reset_outputs_b", {busy_b, ready_b, wr_en_b, copy_b, wr_addr_b, wr_data_b}, 64'd0);
        #17 rst_n = 1'b1;

        // table-driven runs, valid every cycle
        for (int i = 0; i < 4; i++) begin
            drv_q.delete();
            for (int j = 0; j < 8; j++) drv_q.push_back(int'($signed(tv[i].s[j])));
            run_a(0, 0, 1'b1, tv[i].e0, tv[i].e1);
        end

        // valid pattern 1,0,0 over frames of ones
        drv_q.delete();
        for (int j = 0; j < 8; j++) drv_q.push_back(1);
        run_a(2, 0, 1'b1, 40'd4, 40'd4);

        // randomized runs against the model
        for (int r = 0; r < 6; r++) begin
            drv_q.delete();
            for (int j = 0; j < 8; j++) begin
                if (r % 2 == 0) drv_q.push_back(int'($urandom_range(0, 200)) - 100);
                else            drv_q.push_back(int'($urandom_range(0, 65535)) - 32768);
            end
            run_a(1, 0, 1'b0, 40'd0, 40'd0);
        end

        // reset in the middle of frame 0
        drv_q.delete();
        drv_q.push_back(3);
        drv_q.push_back(3);
        @(posedge clk); #1 start_a = 1'b1;
        @(posedge clk); #1 start_a = 1'b0;
        feed_a(2, 0);
        check("a_busy_before_reset", busy_a, 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("a_async_reset_outputs", {busy_a, ready_a, wr_en_a, copy_a, wr_addr_a, wr_data_a}, 64'd0);
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (8) @(negedge clk);
        check("a_idle_after_reset", {busy_a, ready_a}, 64'd0);
        check("a_no_copy_after_reset", copies_a, exp_copies_a);
        drv_q.delete();
        for (int j = 0; j < 4; j++) drv_q.push_back(2);
        for (int j = 0; j < 4; j++) drv_q.push_back(1);
        run_a(0, 0, 1'b1, 40'd16, 40'd4);

        // start held through the whole run: ignored while busy, restarts after DONE
        drv_q.delete();
        for (int j = 0; j < 8; j++) drv_q.push_back(int'($urandom_range(0, 2000)) - 1000);
        run_a(0, 1, 1'b0, 40'd0, 40'd0);
        @(negedge clk); #1;
        check("a_busy_low_after_done", busy_a, 64'd0);
        @(negedge clk); #1;
        check("a_restart_busy", {busy_a, ready_a}, 64'd3);
        drv_q.delete();
        for (int j = 0; j < 8; j++) drv_q.push_back(int'($urandom_range(0, 65535)) - 32768);
        run_a(1, 2, 1'b0, 40'd0, 40'd0);

        // saturation on the 33-bit instance
        @(posedge clk); #1 start_b = 1'b1;
        @(posedge clk); #1 start_b = 1'b0;
        begin
            int nb = 0;
            for (int g = 0; g < 40 && cp_b_cnt == 0; g++) begin
                @(posedge clk); #1;
                valid_b = 1'b0;
                if (ready_b && nb < 8) begin
                    valid_b = 1'b1;
                    data_b  = 16'h8000;
                    nb++;
                end
            end
            valid_b = 1'b0;
            check("b_samples_sent", nb, 8);
        end
        repeat (4) @(negedge clk);
        check("b_write_count", wr_b_cnt, 1);
        check("b_copy_count", cp_b_cnt, 1);
        check("b_idle_at_end", busy_b, 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
